// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART stream blocks.
//   tx_state_e : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS  : payload bits per frame
//   baud_w()   : width of a baud counter that counts 0..clks_per_bit-1
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // At least one bit so a counter always exists, even for tiny divisors.
  function automatic int baud_w(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART frame sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (frame start or abort), wins over run
//   run        : count while a frame is in progress
//   tick       : one-cycle pulse in the last cycle of each bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int W = baud_w(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  // The tick marks the final cycle of a bit, so the sequencer moves to the
  // next bit on the same edge the counter wraps to 0.
  assign tick = run && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte-serial UART transmitter (8 data bits, LSB first,
// optional even parity, 1 or 2 stop bits).
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable; low aborts any frame and holds the block idle
//   tx_data    : byte to send, captured only on accept
//   tx_valid   : producer has a byte
//   tx_ready   : block can accept a byte this cycle (registered)
//   tx         : serial line, idle high (registered)
//   busy       : frame in progress (registered)
//   dbg_state  : current sequencer state
//
// Handshake: a byte is accepted at a rising edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE with ena high the previous cycle, and falls
// at the accept edge. tx_valid may be held high across a frame; it is simply
// ignored until tx_ready returns. The producer need not hold tx_valid after
// the accept edge.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,  // minimum 2
  parameter int PARITY_EN    = 0,    // 1 appends an even parity bit
  parameter int STOP_BITS    = 1     // 1 or 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ena,
  input  logic [7:0] tx_data,
  input  logic      tx_valid,
  output logic      tx_ready,
  output logic      tx,
  output logic      busy,
  output tx_state_e dbg_state
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;   // data bit index, reused to count stop bits
  logic                 par_bit;
  logic                 accept;
  logic                 run;
  logic                 baud_clear;
  logic                 bit_tick;

  // ena low overrides an accept that would otherwise land this edge.
  assign accept     = tx_valid && tx_ready && ena;
  assign run        = (state != IDLE);
  assign baud_clear = accept || !ena;
  assign dbg_state  = state;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .run  (run),
    .tick (bit_tick)
  );

  // tx is driven with the value of the bit being entered, so each transition
  // appears on the same edge as the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      par_bit  <= 1'b0;
    end else if (!ena) begin
      // Abandon any partial frame; it is never resumed.
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= tx_data;
            par_bit  <= ^tx_data;
            bit_idx  <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
          end else begin
            tx       <= 1'b1;
            tx_ready <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              tx      <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_idx == LAST_STOP) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              bit_idx  <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
`timescale 1ns/1ps
module tb_uart_tx_stream;
  import uart_pkg::*;

  localparam int C = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       ena      [2];
  logic       tx_valid [2];
  logic [7:0] tx_data  [2];
  logic       tx_ready_w [2];
  logic       tx_w       [2];
  logic       busy_w     [2];
  tx_state_e  state_w    [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUTs + per-lane model / scoreboard ----------------
  // lane 0: no parity, 1 stop bit; lane 1: even parity, 2 stop bits.
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int PEN = (g == 1) ? 1 : 0;
    localparam int SB  = (g == 1) ? 2 : 1;

    uart_tx_stream #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   (PEN),
      .STOP_BITS   (SB)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena[g]),
      .tx_data  (tx_data[g]),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready_w[g]),
      .tx       (tx_w[g]),
      .busy     (busy_w[g]),
      .dbg_state(state_w[g])
    );

    // Model: on accept, the whole expected tx waveform of the frame is laid
    // out cycle by cycle in exp_q; one entry is consumed per clock.
    logic [0:0] exp_q[$];
    logic [7:0] exp_bytes[$];
    logic m_tx = 1'b1;
    logic m_busy = 1'b0;
    logic m_ready = 1'b0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_bytes.delete();
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
      end else if (!ena[g]) begin
        exp_q.delete();
        exp_bytes.delete();
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
      end else if (exp_q.size() > 0) begin
        m_tx = exp_q.pop_front(); m_busy = 1'b1; m_ready = 1'b0;
      end else if (m_busy) begin
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
      end else if (tx_valid[g] && m_ready) begin
        for (int k = 0; k < C; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < C; k++) exp_q.push_back(tx_data[g][i]);
        if (PEN != 0)
          for (int k = 0; k < C; k++) exp_q.push_back(^tx_data[g]);
        for (int k = 0; k < SB * C; k++) exp_q.push_back(1'b1);
        exp_bytes.push_back(tx_data[g]);
        m_tx = exp_q.pop_front(); m_busy = 1'b1; m_ready = 1'b0;
      end else begin
        m_tx = 1'b1; m_ready = 1'b1;
      end
    end

    // Compare outputs every cycle, and decode the line like a receiver
    // sampling in the middle of each bit.
    int dcnt = 0;
    int dk = 0;
    bit dact = 0;
    logic [7:0] dsh = '0;
    int dec_n = 0;

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("lane%0d_tx", g), 32'(tx_w[g]), 32'(m_tx));
        check($sformatf("lane%0d_busy", g), 32'(busy_w[g]), 32'(m_busy));
        check($sformatf("lane%0d_ready", g), 32'(tx_ready_w[g]), 32'(m_ready));

        if (!rst_n || !ena[g]) begin
          dact = 0;
        end else if (!dact) begin
          if (tx_w[g] === 1'b0) begin
            dact = 1; dcnt = 0;
          end
        end else begin
          dcnt++;
        end

        if (dact && dcnt >= C / 2 && ((dcnt - C / 2) % C) == 0) begin
          dk = (dcnt - C / 2) / C;
          if (dk == 0) begin
            check($sformatf("lane%0d_dec_start", g), 32'(tx_w[g]), 32'd0);
          end else if (dk <= 8) begin
            dsh[dk-1] = tx_w[g];
          end else if (dk == 9 + PEN) begin
            check($sformatf("lane%0d_dec_stop", g), 32'(tx_w[g]), 32'd1);
            dec_n++;
            if (exp_bytes.size() == 0) begin
              checks++; failures++;
              $display("FAIL lane%0d_dec_extra: got byte %02h expected none", g, dsh);
            end else begin
              check($sformatf("lane%0d_dec_byte", g), 32'(dsh), 32'(exp_bytes.pop_front()));
            end
            dact = 0;
          end else begin
            check($sformatf("lane%0d_dec_parity", g), 32'(tx_w[g]), 32'(^dsh));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input int g, input logic [7:0] b, input bit keep, output int t_acc);
    tx_valid[g] = 1'b1;
    tx_data[g]  = b;
    t_acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready_w[g]) begin
        @(posedge clk); #1;
        t_acc = cyc;
        if (!keep) tx_valid[g] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL send_timeout: lane %0d byte %02h never accepted", g, b);
    tx_valid[g] = 1'b0;
  endtask

  // Walks one frame from its first cycle, checking tx at bit centres against
  // a hand-written bit list, the busy length, stop high time and ready return.
  task automatic frame_check(input int g, input string tag, input logic [11:0] lit,
                             input int exp_len, input int exp_stop);
    int nb = 0;
    int nstop = 0;
    for (int k = 0; k <= exp_len; k++) begin
      if (k < exp_len) begin
        if (busy_w[g]) nb++;
        if (k >= exp_len - exp_stop && tx_w[g]) nstop++;
        if ((k % C) == C / 2)
          check($sformatf("%s_bit%0d", tag, k / C), 32'(tx_w[g]), 32'(lit[k / C]));
        if (k == exp_len - 1)
          check($sformatf("%s_ready_low", tag), 32'(tx_ready_w[g]), 32'd0);
      end else begin
        check($sformatf("%s_busy_len", tag), nb, exp_len);
        check($sformatf("%s_stop_len", tag), nstop, exp_stop);
        check($sformatf("%s_ready_back", tag), 32'(tx_ready_w[g]), 32'd1);
        check($sformatf("%s_busy_end", tag), 32'(busy_w[g]), 32'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, t2, nq;
    logic [11:0] lit_a5;
    logic [11:0] lit_07;
    lit_a5 = 12'b00_1101001010;   // start 0, A5 LSB first, stop 1
    lit_07 = 12'b111000001110;    // start 0, 07 LSB first, parity 1, 2 stops

    for (int g = 0; g < 2; g++) begin
      ena[g] = 1'b1; tx_valid[g] = 1'b0; tx_data[g] = 8'h00;
    end

    // 1. reset / idle
    #1 rst_n = 1'b0;
    chk_en = 1;
    @(posedge clk); #1;
    check("rst_tx", 32'(tx_w[0]), 32'd1);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_ready", 32'(tx_ready_w[0]), 32'd0);
    check("rst_state", 32'(state_w[0]), 32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_ready_first", 32'(tx_ready_w[0]), 32'd0);
    @(posedge clk); #1;
    check("rel_ready_second", 32'(tx_ready_w[0]), 32'd1);
    check("rel_tx", 32'(tx_w[0]), 32'd1);
    idle_cycles(2);

    // 2. single byte 0xA5
    send(0, 8'hA5, 1'b0, t0);
    frame_check(0, "a5", lit_a5, 40, 4);
    idle_cycles(2);

    // 3. parity + two stop bits, 0x07
    send(1, 8'h07, 1'b0, t0);
    frame_check(1, "p07", lit_07, 48, 8);
    idle_cycles(2);

    // 4. back-to-back with tx_valid held high
    send(0, 8'h00, 1'b1, t1);
    send(0, 8'hFF, 1'b0, t2);
    check("b2b_gap", t2 - t1, 41);
    idle_cycles(45);

    // 5. abort during data bit 3 of 0x3C
    send(0, 8'h3C, 1'b0, t0);
    idle_cycles(17);
    check("abort_bit3_tx", 32'(tx_w[0]), 32'd1);
    check("abort_pre_busy", 32'(busy_w[0]), 32'd1);
    ena[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_tx", 32'(tx_w[0]), 32'd1);
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_ready", 32'(tx_ready_w[0]), 32'd0);
    check("abort_state", 32'(state_w[0]), 32'(IDLE));
    nq = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) nq++;
      @(posedge clk); #1;
    end
    check("abort_quiet", nq, 0);
    ena[0] = 1'b1;
    idle_cycles(1);
    send(0, 8'h55, 1'b0, t0);
    idle_cycles(45);

    // 6. async reset mid-frame, between clock edges
    send(0, 8'h81, 1'b0, t0);
    idle_cycles(10);
    @(posedge clk); #1;
    check("pre_reset_tx", 32'(tx_w[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_tx", 32'(tx_w[0]), 32'd1);
    check("async_busy", 32'(busy_w[0]), 32'd0);
    check("async_ready", 32'(tx_ready_w[0]), 32'd0);
    check("async_state", 32'(state_w[0]), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(4);

    // scoreboard drain
    check("lane0_bytes_decoded", lane[0].dec_n, 4);
    check("lane1_bytes_decoded", lane[1].dec_n, 1);
    check("lane0_pending", lane[0].exp_bytes.size(), 0);
    check("lane1_pending", lane[1].exp_bytes.size(), 0);

    report();
    $finish;
  end

  initial begin
    #100000;
    checks++; failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    report();
    $finish;
  end

endmodule
